// File: rtl/tick_scheduler.sv
// Shared timebase: one free-running prescaler produces base_tick, which NUM_CH
// channels divide down by their own programmable periods into one-cycle strobes.
module tick_scheduler #(
  parameter int PRESCALE = 5000,
  parameter int NUM_CH   = 4,
  parameter int PER_W    = 16
) (
  input  logic                      clk_50MHz,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [$clog2(NUM_CH)-1:0] cfg_ch,
  input  logic [PER_W-1:0]          cfg_period,
  input  logic                      cfg_enable,
  output logic                      base_tick,
  output logic [NUM_CH-1:0]         ch_tick,
  output logic [NUM_CH-1:0]         ch_active
);

  localparam int                PRE_W    = $clog2(PRESCALE);
  localparam int                CH_W     = $clog2(NUM_CH);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);

  logic [PRE_W-1:0]  r_pre_cnt;
  logic              r_base_tick;
  logic              r_cfg_ready;
  logic [NUM_CH-1:0] r_ch_tick;
  logic [NUM_CH-1:0] r_ch_active;
  logic [PER_W-1:0]  r_period [NUM_CH];
  logic [PER_W-1:0]  r_ch_cnt [NUM_CH];

  logic              w_accept;
  logic [NUM_CH-1:0] w_sel;
  logic              w_wr_active;
  logic [PER_W-1:0]  w_wr_cnt;

  assign w_accept    = cfg_valid && r_cfg_ready;
  assign w_wr_active = cfg_enable && (cfg_period != '0);
  assign w_wr_cnt    = (cfg_period == '0) ? '0 : cfg_period - 1'b1;

  // An out-of-range cfg_ch matches no channel, so the write completes with no effect.
  always_comb begin
    w_sel = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (w_accept && (cfg_ch == CH_W'(i))) begin
        w_sel[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_pre_cnt   <= '0;
      r_base_tick <= 1'b0;
    end else begin
      r_base_tick <= (r_pre_cnt == PRE_LAST);
      r_pre_cnt   <= (r_pre_cnt == PRE_LAST) ? '0 : r_pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (rst) begin
      r_cfg_ready <= 1'b0;
      r_ch_tick   <= '0;
      r_ch_active <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_period[i] <= '0;
        r_ch_cnt[i] <= '0;
      end
    end else begin
      r_cfg_ready <= !w_accept;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_ch_tick[i] <= 1'b0;
        // A write takes priority and swallows a coincident base tick for its channel.
        if (w_sel[i]) begin
          r_period[i]    <= cfg_period;
          r_ch_active[i] <= w_wr_active;
          r_ch_cnt[i]    <= w_wr_cnt;
        end else if (r_base_tick && r_ch_active[i]) begin
          if (r_ch_cnt[i] == '0) begin
            r_ch_tick[i] <= 1'b1;
            r_ch_cnt[i]  <= r_period[i] - 1'b1;
          end else begin
            r_ch_cnt[i]  <= r_ch_cnt[i] - 1'b1;
          end
        end
      end
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign base_tick = r_base_tick;
  assign ch_tick   = r_ch_tick;
  assign ch_active = r_ch_active;

endmodule
